seq_det_param: RTL and testbench

Parametrised serial bit-sequence detector. It is the next generation of the fixed 5-bit "10101" detector.
- Pattern length, default pattern and overlap mode are generics.
- The pattern can be reloaded at runtime.
- Input bits are qualified by a valid strobe, and matches are counted in a saturating counter.
- Sits behind a serial bit source (switch/debounced input or deserialiser) on the FPGA lab board; it drives a LED/pulse and a match-count display.

---
 rtl/seq_det_param_pkg.sv | 12 +
 rtl/seq_det_param_if.sv | 28 ++
 rtl/seq_det_param_sat_counter.sv | 22 ++
 rtl/seq_det_param.sv | 67 ++++++
 tb/tb_seq_det_param.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/seq_det_param_pkg.sv
// Shared constants for the serial sequence detector family.
// Default pattern geometry and the width helper for the fill counter.
package seq_det_param_pkg;

   localparam int         DEF_LEN     = 5;
   localparam logic [4:0] DEF_PATTERN = 5'b10101;

   function automatic int fill_w(input int len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/seq_det_param_if.sv
// Bit-stream, pattern-load and status bundle between a serial source and the detector.
interface seq_det_param_if
   import seq_det_param_pkg::*;
#(
   parameter int LEN   = DEF_LEN,
   parameter int CNT_W = 8
);

   logic                     code;
   logic                     code_vld;
   logic                     pat_load;
   logic [LEN-1:0]           pat_in;
   logic                     clr_cnt;
   logic                     detected;
   logic [CNT_W-1:0]         match_cnt;
   logic [fill_w(LEN)-1:0]   fill;

   modport master (
      output code, code_vld, pat_load, pat_in, clr_cnt,
      input  detected, match_cnt, fill
   );

   modport slave (
      input  code, code_vld, pat_load, pat_in, clr_cnt,
      output detected, match_cnt, fill
   );

endinterface

// File: rtl/seq_det_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] MAX = {W{1'b1}};

   always_ff @(posedge CLK) begin
      if (RST || clr) begin
         q <= '0;
      end else if (inc && (q != MAX)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector with runtime pattern reload,
// valid-qualified input, optional overlapping matches and a saturating match count.
module seq_det_param
   import seq_det_param_pkg::*;
#(
   parameter int             LEN     = DEF_LEN,
   parameter logic [LEN-1:0] PATTERN = LEN'(DEF_PATTERN),
   parameter bit             OVERLAP = 1'b1,
   parameter int             CNT_W   = 8
) (
   input  logic             CLK,
   input  logic             RST,
   seq_det_param_if.slave   bus
);

   localparam int             FW   = fill_w(LEN);
   localparam logic [FW-1:0]  FULL = FW'(LEN);

   logic [LEN-1:0] hist;
   logic [LEN-1:0] pat;
   logic [FW-1:0]  fill_q;
   logic           det_q;

   logic [LEN-1:0] hist_nx;
   logic [FW-1:0]  fill_nx;
   logic           match_now;

   // Match is judged on the post-shift window so the pulse lands one edge after the last bit.
   always_comb begin
      hist_nx   = LEN'({hist, bus.code});
      fill_nx   = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
      match_now = bus.code_vld && !bus.pat_load &&
                  (fill_nx == FULL) && (hist_nx == pat);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         hist   <= '0;
         pat    <= PATTERN;
         fill_q <= '0;
         det_q  <= 1'b0;
      end else if (bus.pat_load) begin
         pat    <= bus.pat_in;
         fill_q <= '0;
         det_q  <= 1'b0;
      end else if (bus.code_vld) begin
         hist   <= hist_nx;
         // Non-overlap mode masks the stale window by restarting the fill count.
         fill_q <= (match_now && !OVERLAP) ? '0 : fill_nx;
         det_q  <= match_now;
      end else begin
         det_q  <= 1'b0;
      end
   end

   sat_counter #(.W(CNT_W)) u_cnt (
      .CLK (CLK),
      .RST (RST),
      .clr (bus.clr_cnt),
      .inc (match_now),
      .q   (bus.match_cnt)
   );

   assign bus.detected = det_q;
   assign bus.fill     = fill_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: overlap, non-overlap and narrow-counter instances.
module tb_seq_det_param;
   import seq_det_param_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   always #5 CLK = ~CLK;

   seq_det_param_if #(.LEN(5), .CNT_W(8)) b0 ();
   seq_det_param_if #(.LEN(5), .CNT_W(8)) b1 ();
   seq_det_param_if #(.LEN(5), .CNT_W(2)) b2 ();

   seq_det_param #(.LEN(5), .PATTERN(5'b10101), .OVERLAP(1'b1), .CNT_W(8)) u0 (
      .CLK(CLK), .RST(RST), .bus(b0));
   seq_det_param #(.LEN(5), .PATTERN(5'b10101), .OVERLAP(1'b0), .CNT_W(8)) u1 (
      .CLK(CLK), .RST(RST), .bus(b1));
   seq_det_param #(.LEN(5), .PATTERN(5'b10101), .OVERLAP(1'b1), .CNT_W(2)) u2 (
      .CLK(CLK), .RST(RST), .bus(b2));

   typedef struct {
      logic       rst;
      logic       code;
      logic       vld;
      logic       load;
      logic [4:0] pat;
      logic       clr;
      logic       det;
      int         cnt;
      int         fill;
   } vec_t;

   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Same stimulus goes to all three instances; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic r, input logic c, input logic v,
                       input logic l, input logic [4:0] p, input logic k);
      RST = r;
      b0.code = c; b0.code_vld = v; b0.pat_load = l; b0.pat_in = p; b0.clr_cnt = k;
      b1.code = c; b1.code_vld = v; b1.pat_load = l; b1.pat_in = p; b1.clr_cnt = k;
      b2.code = c; b2.code_vld = v; b2.pat_load = l; b2.pat_in = p; b2.clr_cnt = k;
      @(posedge CLK);
      #1;
   endtask

   task automatic add(input logic r, input logic c, input logic v, input logic l,
                      input logic [4:0] p, input logic k, input logic d,
                      input int n, input int f);
      vec_t e;
      e.rst = r; e.code = c; e.vld = v; e.load = l; e.pat = p; e.clr = k;
      e.det = d; e.cnt = n; e.fill = f;
      tbl.push_back(e);
   endtask

   logic [11:0] s2;
   int          f2 [12];
   logic [11:0] d2;

   initial begin
      b0.code = 0; b0.code_vld = 0; b0.pat_load = 0; b0.pat_in = '0; b0.clr_cnt = 0;
      b1.code = 0; b1.code_vld = 0; b1.pat_load = 0; b1.pat_in = '0; b1.clr_cnt = 0;
      b2.code = 0; b2.code_vld = 0; b2.pat_load = 0; b2.pat_in = '0; b2.clr_cnt = 0;

      //   rst code vld load pat       clr det cnt fill
      // overlapping 1010101
      add(1, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
      add(0, 1, 1, 0, 5'b00000, 0, 0, 0, 1);
      add(0, 0, 1, 0, 5'b00000, 0, 0, 0, 2);
      add(0, 1, 1, 0, 5'b00000, 0, 0, 0, 3);
      add(0, 0, 1, 0, 5'b00000, 0, 0, 0, 4);
      add(0, 1, 1, 0, 5'b00000, 0, 1, 1, 5);
      add(0, 0, 1, 0, 5'b00000, 0, 0, 1, 5);
      add(0, 1, 1, 0, 5'b00000, 0, 1, 2, 5);
      add(0, 0, 0, 0, 5'b00000, 1, 0, 0, 5);
      // runtime reload to 11100, load-edge bit discarded
      add(1, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
      add(0, 1, 1, 0, 5'b00000, 0, 0, 0, 1);
      add(0, 1, 1, 0, 5'b00000, 0, 0, 0, 2);
      add(0, 0, 1, 0, 5'b00000, 0, 0, 0, 3);
      add(0, 1, 1, 1, 5'b11100, 0, 0, 0, 0);
      add(0, 1, 1, 0, 5'b00000, 0, 0, 0, 1);
      add(0, 1, 1, 0, 5'b00000, 0, 0, 0, 2);
      add(0, 1, 1, 0, 5'b00000, 0, 0, 0, 3);
      add(0, 0, 1, 0, 5'b00000, 0, 0, 0, 4);
      add(0, 0, 1, 0, 5'b00000, 0, 1, 1, 5);
      // reset restores 10101 and drops a partial sequence
      add(1, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
      add(0, 1, 1, 0, 5'b00000, 0, 0, 0, 1);
      add(0, 0, 1, 0, 5'b00000, 0, 0, 0, 2);
      add(0, 1, 1, 0, 5'b00000, 0, 0, 0, 3);
      add(0, 0, 1, 0, 5'b00000, 0, 0, 0, 4);
      add(1, 1, 1, 0, 5'b00000, 0, 0, 0, 0);
      add(0, 1, 1, 0, 5'b00000, 0, 0, 0, 1);
      add(0, 1, 1, 0, 5'b00000, 0, 0, 0, 2);
      add(0, 0, 1, 0, 5'b00000, 0, 0, 0, 3);
      add(0, 1, 1, 0, 5'b00000, 0, 0, 0, 4);
      add(0, 0, 1, 0, 5'b00000, 0, 0, 0, 5);
      add(0, 1, 1, 0, 5'b00000, 0, 1, 1, 5);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].code, tbl[i].vld, tbl[i].load, tbl[i].pat, tbl[i].clr);
         chk($sformatf("tbl%0d.det", i),  int'(b0.detected), int'(tbl[i].det));
         chk($sformatf("tbl%0d.cnt", i),  int'(b0.match_cnt), tbl[i].cnt);
         chk($sformatf("tbl%0d.fill", i), int'(b0.fill), tbl[i].fill);
      end

      // Non-overlap: 1010101 then 10101; fresh window after bit 5 is 01101, then slides.
      s2 = 12'b1010_1011_0101;
      f2 = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 5, 5, 0};
      d2 = 12'b0000_1000_0001;
      step(1, 0, 0, 0, 5'b0, 0);
      chk("novl.rst.fill", int'(b1.fill), 0);
      for (int i = 0; i < 12; i++) begin
         step(0, s2[11-i], 1, 0, 5'b0, 0);
         chk($sformatf("novl.b%0d.det", i+1),  int'(b1.detected), int'(d2[11-i]));
         chk($sformatf("novl.b%0d.fill", i+1), int'(b1.fill), f2[i]);
      end
      chk("novl.cnt", int'(b1.match_cnt), 2);

      // Valid gaps with code=0 are ignored.
      step(1, 0, 0, 0, 5'b0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, ((i % 2) == 0) ? 1'b1 : 1'b0, 1, 0, 5'b0, 0);
         chk($sformatf("gap.b%0d.det", i+1), int'(b0.detected), (i == 4) ? 1 : 0);
         chk($sformatf("gap.b%0d.fill", i+1), int'(b0.fill), i + 1);
         for (int g = 0; g < 3; g++) begin
            step(0, 0, 0, 0, 5'b0, 0);
            chk($sformatf("gap.b%0d.g%0d.det", i+1, g), int'(b0.detected), 0);
            chk($sformatf("gap.b%0d.g%0d.fill", i+1, g), int'(b0.fill), i + 1);
         end
      end
      chk("gap.cnt", int'(b0.match_cnt), 1);

      // Two-bit counter: six overlapping matches saturate at 3.
      step(1, 0, 0, 0, 5'b0, 0);
      chk("sat.rst.cnt", int'(b2.match_cnt), 0);
      step(0, 1, 1, 0, 5'b0, 0);
      for (int m = 0; m < 7; m++) begin
         step(0, 0, 1, 0, 5'b0, 0);
         step(0, 1, 1, 0, 5'b0, 0);
         if (m >= 1) begin
            chk($sformatf("sat.m%0d.det", m), int'(b2.detected), 1);
            chk($sformatf("sat.m%0d.cnt", m), int'(b2.match_cnt), (m > 3) ? 3 : m);
         end
      end
      // Clear coinciding with a match: count clears, pulse still fires.
      step(0, 0, 1, 0, 5'b0, 0);
      chk("clr.pre.det", int'(b2.detected), 0);
      step(0, 1, 1, 0, 5'b0, 1);
      chk("clr.det", int'(b2.detected), 1);
      chk("clr.cnt", int'(b2.match_cnt), 0);
      step(0, 0, 1, 0, 5'b0, 0);
      step(0, 1, 1, 0, 5'b0, 0);
      chk("clr.after.cnt", int'(b2.match_cnt), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
